interrupt_ctrl: RTL

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

---
 rtl/interrupt_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/interrupt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_ctrl
// Description : Five-source interrupt controller with IF (0xFF0F) and
//               IE (0xFFFF) registers, edge capture of peripheral requests,
//               fixed priority (vblank highest) and a three-state service
//               handshake toward the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        wr,
  input  logic [4:0]  int_req,
  output logic [4:0]  int_ack,
  output logic        cpu_int_req,
  output logic [7:0]  cpu_int_vec,
  input  logic        cpu_int_ack
);

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  if_reg;
  logic [7:0]  ie_reg;
  logic [4:0]  req_d;
  logic [2:0]  svc_idx;

  logic [4:0]  req_edge;
  logic [4:0]  pending;
  logic [2:0]  winner;
  logic        take_svc;
  logic [4:0]  svc_clr;
  logic [4:0]  if_next;
  logic        unused_rd;

  // The read strobe does not qualify dout; it is accepted only for bus symmetry.
  assign unused_rd = rd;

  // Vector for a source index: 0x40 + 8*idx.
  function automatic logic [7:0] vec_of(input logic [2:0] idx);
    return 8'h40 + {2'b00, idx, 3'b000};
  endfunction

  assign req_edge = int_req & ~req_d;
  assign pending  = if_reg & ie_reg[4:0];
  assign take_svc = (state == IDLE) && cpu_int_ack && (pending != 5'd0);

  // Lowest-index pending bit wins; scan downward so the lowest set bit is last.
  always_comb begin
    winner = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) winner = 3'(i);
    end
  end

  assign svc_clr = take_svc ? (5'd1 << winner) : 5'd0;

  // IF next value: bus write, then service clear, then edge set (set wins).
  always_comb begin
    if_next = if_reg;
    if (wr && (a == ADDR_IF)) if_next = din[4:0];
    if_next = if_next & ~svc_clr;
    if_next = if_next | req_edge;
  end

  // Combinational read port; unmapped addresses float high.
  always_comb begin
    case (a)
      ADDR_IF: dout = {3'b111, if_reg};
      ADDR_IE: dout = ie_reg;
      default: dout = 8'hFF;
    endcase
  end

  // CPU-facing request and vector; frozen on svc_idx while servicing.
  always_comb begin
    if (state == IDLE) begin
      cpu_int_req = |pending;
      cpu_int_vec = (pending != 5'd0) ? vec_of(winner) : 8'h00;
    end else begin
      cpu_int_req = 1'b0;
      cpu_int_vec = vec_of(svc_idx);
    end
  end

  // Register file and request edge history; active in every FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_reg <= 5'd0;
      ie_reg <= 8'd0;
      req_d  <= 5'd0;
    end else begin
      if_reg <= if_next;
      req_d  <= int_req;
      if (wr && (a == ADDR_IE)) ie_reg <= din;
    end
  end

  // Service handshake FSM with registered one-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      svc_idx <= 3'd0;
      int_ack <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          int_ack <= 5'd0;
          if (take_svc) begin
            svc_idx <= winner;
            int_ack <= 5'd1 << winner;
            state   <= ACK;
          end
        end
        ACK: begin
          int_ack <= 5'd0;
          state   <= WAIT_REL;
        end
        WAIT_REL: begin
          int_ack <= 5'd0;
          if (!cpu_int_ack) state <= IDLE;
        end
        default: begin
          int_ack <= 5'd0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
